// File: rtl/sync_handshake_ctrl.sv
// sync_handshake_ctrl
//   Source-side sequencer for a 4-phase req/ack crossing. A word accepted on
//   the valid/ready port is held on data_out while req_out is raised, the
//   synchronized ack_in is awaited high, req_out is dropped, and ack_in is
//   awaited low again. Each wait phase can be aborted by a cycle timeout.
//
// Ports
//   clk, rst      source-domain clock, synchronous active-high reset
//   s_valid/s_ready/s_data   upstream word handshake
//   data_out      captured word, stable from accept until back in IDLE
//   req_out       request level toward the destination (idle level = INIT)
//   ack_in        destination ack, already synchronized into clk
//   busy          high in any state other than IDLE
//   done          one-cycle pulse on normal handshake completion
//   timeout_err   sticky abort flag, cleared by err_clr
module sync_handshake_ctrl #(
  parameter int   WIDTH   = 8,
  parameter int   TIMEOUT = 255,
  parameter logic INIT    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic [WIDTH-1:0] data_out,
  output logic             req_out,
  input  logic             ack_in,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_REL   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // True on the last allowed cycle of a wait phase; never true with TIMEOUT=0.
  function automatic logic phase_expired(input logic [CNT_W-1:0] cnt);
    return (TIMEOUT != 0) && (cnt == CNT_LAST);
  endfunction

  // A stale-high ack from a previous transfer must not let a new one start.
  assign s_ready     = (state_q == ST_IDLE) && !ack_in && !rst;
  assign busy        = (state_q != ST_IDLE);
  assign req_out     = req_q;
  assign data_out    = data_q;
  assign done        = done_q;
  assign timeout_err = err_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;

    // Clear first so an abort on the same edge overrides it.
    if (err_clr) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_valid && s_ready) begin
          state_d = ST_REQ;
          req_d   = ~INIT;
          data_d  = s_data;
          cnt_d   = '0;
        end
      end
      ST_REQ: begin
        // Exit condition takes priority over the timeout on the same edge.
        if (ack_in) begin
          state_d = ST_REL;
          req_d   = INIT;
          cnt_d   = '0;
        end else if (phase_expired(cnt_q)) begin
          state_d = ST_DRAIN;
          req_d   = INIT;
          err_d   = 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REL: begin
        if (!ack_in) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (phase_expired(cnt_q)) begin
          state_d = ST_DRAIN;
          req_d   = INIT;
          err_d   = 1'b1;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Wait out a stuck ack without a timeout; no done pulse on this path.
        if (!ack_in) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= INIT;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sync_handshake_ctrl.sv
// tb_sync_handshake_ctrl
//   Directed bench for sync_handshake_ctrl with WIDTH=8, TIMEOUT=4, INIT=0.
//   Inputs change and outputs are observed 1 time unit after each rising edge.
module tb_sync_handshake_ctrl;

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic [7:0] data_out;
  logic       req_out;
  logic       ack_in;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic       err_clr;

  int errors = 0;
  int checks = 0;

  sync_handshake_ctrl #(
    .WIDTH   (8),
    .TIMEOUT (4),
    .INIT    (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .data_out    (data_out),
    .req_out     (req_out),
    .ack_in      (ack_in),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; ack_in = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_req",   req_out,     1'b0);
    chk("rst_busy",  busy,        1'b0);
    chk("rst_done",  done,        1'b0);
    chk("rst_err",   timeout_err, 1'b0);
    chk("rst_data",  data_out,    8'h00);
    chk("rst_ready", s_ready,     1'b0);
    rst = 1'b0; #1;
    chk("idle_ready", s_ready, 1'b1);

    // T1: normal handshake, ack rises 3 cycles after req, falls 3 after release
    s_valid = 1'b1; s_data = 8'hA5;
    tick();
    chk("t1_req_on",  req_out,  1'b1);
    chk("t1_busy",    busy,     1'b1);
    chk("t1_data",    data_out, 8'hA5);
    chk("t1_ready0",  s_ready,  1'b0);
    s_valid = 1'b0; s_data = 8'h00;
    tick(); chk("t1_req_c1", req_out, 1'b1);
    tick(); chk("t1_req_c2", req_out, 1'b1);
    ack_in = 1'b1;
    tick();
    chk("t1_req_off", req_out, 1'b0);
    chk("t1_busy_rel", busy,   1'b1);
    chk("t1_nodone",  done,    1'b0);
    tick(); tick();
    chk("t1_data_rel", data_out, 8'hA5);
    ack_in = 1'b0;
    tick();
    chk("t1_done",    done,     1'b1);
    chk("t1_idle",    busy,     1'b0);
    chk("t1_data_hold", data_out, 8'hA5);
    chk("t1_ready1",  s_ready,  1'b1);
    chk("t1_noerr",   timeout_err, 1'b0);
    tick();
    chk("t1_done_pulse", done, 1'b0);

    // T2: stale-high ack blocks acceptance
    ack_in = 1'b1; s_valid = 1'b1; s_data = 8'h5A; #1;
    chk("t2_ready0", s_ready, 1'b0);
    tick(); tick();
    chk("t2_noaccept_busy", busy,     1'b0);
    chk("t2_noaccept_data", data_out, 8'hA5);
    ack_in = 1'b0; #1;
    chk("t2_ready1", s_ready, 1'b1);
    tick();
    chk("t2_accept_busy", busy,     1'b1);
    chk("t2_accept_data", data_out, 8'h5A);
    chk("t2_accept_req",  req_out,  1'b1);
    s_valid = 1'b0;
    ack_in = 1'b1; tick();
    chk("t2_rel_req", req_out, 1'b0);
    ack_in = 1'b0; tick();
    chk("t2_done", done, 1'b1);
    tick();

    // T3: ack never rises -> REQ aborts after 4 cycles
    s_valid = 1'b1; s_data = 8'h33;
    tick();
    s_valid = 1'b0;
    chk("t3_req_on", req_out, 1'b1);
    tick(); tick(); tick();
    chk("t3_req_c3", req_out,     1'b1);
    chk("t3_err_c3", timeout_err, 1'b0);
    tick();
    chk("t3_req_abort", req_out,     1'b0);
    chk("t3_err_set",   timeout_err, 1'b1);
    chk("t3_drain",     busy,        1'b1);
    chk("t3_nodone",    done,        1'b0);
    tick();
    chk("t3_idle",      busy,        1'b0);
    chk("t3_nodone2",   done,        1'b0);
    chk("t3_err_stick", timeout_err, 1'b1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t3_err_clr", timeout_err, 1'b0);

    // T4: ack stuck high -> REL aborts after 4 cycles; clear and set collide
    s_valid = 1'b1; s_data = 8'h44;
    tick();
    s_valid = 1'b0; ack_in = 1'b1;
    tick();
    chk("t4_rel_req", req_out, 1'b0);
    tick(); tick(); tick();
    chk("t4_rel_busy", busy,        1'b1);
    chk("t4_rel_err",  timeout_err, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_set_wins", timeout_err, 1'b1);
    chk("t4_drain_busy",   busy,        1'b1);
    chk("t4_nodone",       done,        1'b0);
    tick(); tick();
    chk("t4_drain_hold",  busy,    1'b1);
    chk("t4_drain_ready", s_ready, 1'b0);
    chk("t4_drain_data",  data_out, 8'h44);
    ack_in = 1'b0;
    tick();
    chk("t4_idle",   busy, 1'b0);
    chk("t4_nodone2", done, 1'b0);

    // T5: reset in REQ, with timeout_err still set from T4
    s_valid = 1'b1; s_data = 8'h55;
    tick();
    s_valid = 1'b0;
    tick();
    chk("t5_in_req", req_out, 1'b1);
    rst = 1'b1;
    tick();
    chk("t5_req",  req_out,     1'b0);
    chk("t5_busy", busy,        1'b0);
    chk("t5_done", done,        1'b0);
    chk("t5_err",  timeout_err, 1'b0);
    chk("t5_data", data_out,    8'h00);
    rst = 1'b0;

    // T6: back-to-back words with s_valid held high
    s_valid = 1'b1; s_data = 8'h01;
    tick();
    chk("t6_w1_data", data_out, 8'h01);
    s_data = 8'h02;
    tick(); ack_in = 1'b1;
    chk("t6_w1_hold", data_out, 8'h01);
    tick(); ack_in = 1'b0;
    chk("t6_w1_rel", req_out, 1'b0);
    tick();
    chk("t6_w1_done", done, 1'b1);
    tick();
    chk("t6_w2_data", data_out, 8'h02);
    chk("t6_w2_req",  req_out,  1'b1);
    chk("t6_w2_nodone", done,   1'b0);
    s_data = 8'h03;
    tick(); ack_in = 1'b1;
    chk("t6_w2_hold", data_out, 8'h02);
    tick(); ack_in = 1'b0;
    tick();
    chk("t6_w2_done", done, 1'b1);
    tick();
    chk("t6_w3_data", data_out, 8'h03);
    s_valid = 1'b0;
    tick(); ack_in = 1'b1;
    tick(); ack_in = 1'b0;
    tick();
    chk("t6_w3_done", done, 1'b1);
    tick();
    chk("t6_end_idle", busy, 1'b0);
    chk("t6_end_done", done, 1'b0);
    chk("t6_end_err",  timeout_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
